uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter that serialises one data word per valid/ready handshake into a standard asynchronous frame: start bit, DATA_W data bits LSB-first, optional parity, then one or two stop bits. It replaces the fixed 8-bit start/data/stop bit-select path with a self-timed frame engine that has its own baud counter, bit counter and state machine. It sits between the transmit-side producer (FIFO or register interface) and the serial `tx` pin.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; must be ≥ 2.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Used only when `UART_TX_PARITY_EN` is defined.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_W  word to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while any frame bit is being driven.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro defined.
- Handshake occurs when `tx_valid && tx_ready` on a rising edge. On that edge:
  - `tx_data` is latched into a shift register.
  - Parity is computed from the latched word.
  - The FSM enters START.
- Each state holds its bit for exactly CLKS_PER_BIT cycles. The baud counter restarts at 0 on every bit boundary.
- START drives `tx`=0.
- DATA drives the shift-register LSB, then shifts right once per bit; a bit counter runs 0..DATA_W-1.
- PARITY drives the XOR of the data bits, inverted when PARITY_ODD=1.
- STOP drives `tx`=1 for STOP_BITS bit periods.
- After STOP, the FSM goes to START if a handshake occurs on the final STOP cycle; otherwise it goes to IDLE.
- `tx_valid` is ignored while `tx_ready`=0. The producer holds `tx_data` stable only on the handshake cycle.
- Arithmetic and widths:
  - baud counter is $clog2(CLKS_PER_BIT) bits;
  - bit counter is $clog2(DATA_W+1) bits;
  - no counter wraps except by explicit reload.

## Timing
- Reset values: `tx`=1, `tx_ready`=0, `tx_busy`=0, FSM=IDLE, all counters 0.
- `tx_ready` rises on the first cycle after `rst` is released.
- `tx` is registered. After a handshake on cycle N, `tx` is 0 from cycle N+1 through N+CLKS_PER_BIT.
- Frame length F = CLKS_PER_BIT × (1 + DATA_W + P + STOP_BITS), where P is 1 with parity and 0 without.
- `tx_busy` is high for exactly F cycles per frame.
- `tx_ready` is high in IDLE and on the last cycle of the last STOP bit; it is low otherwise.
- Back-to-back frames: a handshake on the final STOP cycle gives a start bit on the next cycle, with no idle gap.
- Reset mid-frame: on the next cycle `tx`=1 and `tx_busy`=0, and the partial frame is abandoned. `tx_ready` returns one cycle after reset is deasserted.
- `tx_valid` asserted during reset is ignored.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and the parity register are compiled in; frames carry a parity bit after the data bits.
- `UART_TX_PARITY_EN` undefined: no parity logic; STOP directly follows DATA; `PARITY_ODD` has no effect.

## Structure
- Shared package `uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - line-level constants `UART_IDLE_LVL`=1 and `UART_START_LVL`=0, reused by the future receiver.
- One sub-module, `uart_baud_tick`:
  - parametrised by CLKS_PER_BIT;
  - inputs: `clk`, `rst`, and a restart input;
  - output: a one-cycle `tick` pulse at each bit boundary.
- All frame logic stays in `uart_tx_frame`.

## Test plan
- Reset release, CLKS_PER_BIT=4, DATA_W=8, no parity:
  - `tx`=1, `tx_busy`=0 throughout reset;
  - `tx_ready`=1 on the first cycle after release.
- Send 0xA5, no parity: `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; `tx_busy` is high for 40 cycles.
- Parity enabled, 0xA5:
  - even parity gives a parity bit of 0, frame 44 cycles;
  - PARITY_ODD=1 gives a parity bit of 1.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high:
  - the second handshake lands on the final stop cycle;
  - the second start bit follows with no idle cycle;
  - STOP_BITS=2 gives 8 stop cycles.
- Assert `rst` during data bit 3, then release:
  - `tx`=1 on the cycle after assertion;
  - a new 0x3C then sends a complete, correct frame.
- `tx_valid` pulsed during a frame: no handshake occurs, and the frame in progress is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and serial line levels,
// common to the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses tick on the last
// clock of each bit period. restart holds the count at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: rst is synchronous, so it lives inside the clocked block and is
  // only honoured on a rising edge; all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_W data bits LSB-first, optional parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              ready_idle;
  logic              last_stop;
  logic              tick;
  logic              handshake;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state == IDLE),
    .tick   (tick)
  );

  // Ready in IDLE (once out of reset) and on the very last clock of the frame,
  // which is what lets a new word start with no idle gap.
  assign tx_ready  = ready_idle || (last_stop && tick);
  assign handshake = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ready_idle <= 1'b0;
      last_stop  <= 1'b0;
      tx         <= UART_IDLE_LVL;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (handshake) begin
      shreg      <= tx_data;
      bit_cnt    <= '0;
      ready_idle <= 1'b0;
      last_stop  <= 1'b0;
      tx         <= UART_START_LVL;
      tx_busy    <= 1'b1;
      state      <= START;
`ifdef UART_TX_PARITY_EN
      parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
    end else begin
      case (state)
        IDLE: ready_idle <= 1'b1;
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state     <= STOP;
              tx        <= UART_IDLE_LVL;
              last_stop <= (STOP_BITS == 1);
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state     <= STOP;
            tx        <= UART_IDLE_LVL;
            last_stop <= (STOP_BITS == 1);
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              state      <= IDLE;
              tx_busy    <= 1'b0;
              ready_idle <= 1'b1;
              last_stop  <= 1'b0;
            end else begin
              last_stop  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
